// File: rtl/axi_lite_dmem.sv
// AXI-lite slave data memory: word-organised, byte-writable, fixed-latency
// read and write channels running as independent state machines.
module axi_lite_dmem #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                    RD_LATENCY  = 1,
  parameter int                    WR_LATENCY  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int RD_CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam int WR_CW = (WR_LATENCY > 1) ? $clog2(WR_LATENCY) : 1;
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(DEPTH_WORDS * 4);

  localparam logic [1:0] R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2;
  localparam logic [1:0] W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2;
  localparam logic [1:0] RESP_OKAY = 2'b00, RESP_DECERR = 2'b11;

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return (a >= BASE_ADDR) && ((a - BASE_ADDR) < MEM_BYTES);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2'd2);
  endfunction

  logic [DATA_WIDTH-1:0] mem_r [DEPTH_WORDS];

  logic [1:0]            rd_state_r;
  logic [RD_CW-1:0]      rd_cnt_r;
  logic [IDX_W-1:0]      rd_idx_r;
  logic                  rd_ok_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic [1:0]            rresp_r;
  logic [IDX_W-1:0]      rd_idx_s;
  logic                  rd_ok_s;
  logic                  rd_fire_s;

  logic [1:0]            wr_state_r;
  logic [WR_CW-1:0]      wr_cnt_r;
  logic                  aw_got_r;
  logic                  w_got_r;
  logic [IDX_W-1:0]      wr_idx_r;
  logic                  wr_ok_r;
  logic [DATA_WIDTH-1:0] wr_data_r;
  logic [3:0]            wr_strb_r;
  logic [1:0]            bresp_r;
  logic                  aw_hs_s;
  logic                  w_hs_s;
  logic                  wr_both_s;
  logic [IDX_W-1:0]      wr_idx_s;
  logic                  wr_ok_s;
  logic [DATA_WIDTH-1:0] wr_data_s;
  logic [3:0]            wr_strb_s;
  logic                  wr_fire_s;

  assign arready = (rd_state_r == R_IDLE);
  assign rvalid  = (rd_state_r == R_RESP);
  assign rdata   = rdata_r;
  assign rresp   = rresp_r;
  assign awready = (wr_state_r == W_IDLE) && !aw_got_r;
  assign wready  = (wr_state_r == W_IDLE) && !w_got_r;
  assign bvalid  = (wr_state_r == W_RESP);
  assign bresp   = bresp_r;

  // Read decode source and the edge that samples read data into rdata_r
  always_comb begin
    rd_idx_s  = rd_idx_r;
    rd_ok_s   = rd_ok_r;
    rd_fire_s = 1'b0;
    case (rd_state_r)
      R_IDLE: begin
        rd_idx_s  = addr_idx(araddr);
        rd_ok_s   = addr_ok(araddr);
        rd_fire_s = arvalid && (RD_LATENCY == 1);
      end
      R_WAIT:  rd_fire_s = (rd_cnt_r == RD_CW'(1));
      default: rd_fire_s = 1'b0;
    endcase
  end

  // Read channel state machine and registered response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_r <= R_IDLE;
      rd_cnt_r   <= {RD_CW{1'b0}};
      rd_idx_r   <= {IDX_W{1'b0}};
      rd_ok_r    <= 1'b0;
      rdata_r    <= {DATA_WIDTH{1'b0}};
      rresp_r    <= RESP_OKAY;
    end else begin
      if (rd_fire_s) begin
        rdata_r <= rd_ok_s ? mem_r[rd_idx_s] : {DATA_WIDTH{1'b0}};
        rresp_r <= rd_ok_s ? RESP_OKAY : RESP_DECERR;
      end
      case (rd_state_r)
        R_IDLE: begin
          if (arvalid) begin
            rd_idx_r   <= rd_idx_s;
            rd_ok_r    <= rd_ok_s;
            rd_cnt_r   <= RD_CW'(RD_LATENCY - 1);
            rd_state_r <= (RD_LATENCY == 1) ? R_RESP : R_WAIT;
          end
        end
        R_WAIT: begin
          if (rd_fire_s) rd_state_r <= R_RESP;
          else           rd_cnt_r   <= rd_cnt_r - RD_CW'(1);
        end
        R_RESP: begin
          if (rready) rd_state_r <= R_IDLE;
        end
        default: rd_state_r <= R_IDLE;
      endcase
    end
  end

  // Write operands come from the live bus on the cycle a channel is still handshaking
  always_comb begin
    aw_hs_s   = awvalid && awready;
    w_hs_s    = wvalid && wready;
    wr_both_s = (aw_got_r || aw_hs_s) && (w_got_r || w_hs_s);
    wr_idx_s  = aw_got_r ? wr_idx_r : addr_idx(awaddr);
    wr_ok_s   = aw_got_r ? wr_ok_r : addr_ok(awaddr);
    wr_data_s = w_got_r ? wr_data_r : wdata;
    wr_strb_s = w_got_r ? wr_strb_r : wstrb;
    case (wr_state_r)
      W_IDLE:  wr_fire_s = wr_both_s && (WR_LATENCY == 1);
      W_WAIT:  wr_fire_s = (wr_cnt_r == WR_CW'(1));
      default: wr_fire_s = 1'b0;
    endcase
  end

  // Write channel state machine, operand capture and registered response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_r <= W_IDLE;
      wr_cnt_r   <= {WR_CW{1'b0}};
      aw_got_r   <= 1'b0;
      w_got_r    <= 1'b0;
      wr_idx_r   <= {IDX_W{1'b0}};
      wr_ok_r    <= 1'b0;
      wr_data_r  <= {DATA_WIDTH{1'b0}};
      wr_strb_r  <= 4'h0;
      bresp_r    <= RESP_OKAY;
    end else begin
      if (wr_fire_s) bresp_r <= wr_ok_s ? RESP_OKAY : RESP_DECERR;
      case (wr_state_r)
        W_IDLE: begin
          if (aw_hs_s) begin
            aw_got_r <= 1'b1;
            wr_idx_r <= wr_idx_s;
            wr_ok_r  <= wr_ok_s;
          end
          if (w_hs_s) begin
            w_got_r   <= 1'b1;
            wr_data_r <= wdata;
            wr_strb_r <= wstrb;
          end
          if (wr_both_s) begin
            wr_cnt_r   <= WR_CW'(WR_LATENCY - 1);
            wr_state_r <= (WR_LATENCY == 1) ? W_RESP : W_WAIT;
          end
        end
        W_WAIT: begin
          if (wr_fire_s) wr_state_r <= W_RESP;
          else           wr_cnt_r   <= wr_cnt_r - WR_CW'(1);
        end
        W_RESP: begin
          if (bready) begin
            aw_got_r   <= 1'b0;
            w_got_r    <= 1'b0;
            wr_state_r <= W_IDLE;
          end
        end
        default: wr_state_r <= W_IDLE;
      endcase
    end
  end

  // Byte-lane commit; held off while reset is asserted so a dropped write never lands
  always_ff @(posedge clk) begin
    if (!rst && wr_fire_s && wr_ok_s) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb_s[b]) mem_r[wr_idx_s][8*b +: 8] <= wr_data_s[8*b +: 8];
      end
    end
  end

endmodule

// File: doc/axi_lite_dmem.md
Name: axi_lite_dmem

Overview:
- AXI-lite slave data memory sitting directly downstream of the LSU; it consumes the LSU's AR/R and AW/W/B traffic.
- Word-organised byte-writable SRAM model with a configurable fixed response latency.
- Read and write channels run as independent FSMs, so one read and one write can be outstanding at the same time.
- Out-of-range accesses complete with DECERR, so the core never hangs on a bad address.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width; must be 32.
- DEPTH_WORDS, 4096, number of 32-bit words (16 KiB).
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- RD_LATENCY, 1, cycles from AR handshake to rvalid; must be >= 1.
- WR_LATENCY, 1, cycles from completion of both AW and W to bvalid; must be >= 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- araddr  in  ADDR_WIDTH  read address.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  DATA_WIDTH  read data, full aligned word.
- rresp  out  2  read response: 2'b00 OKAY, 2'b11 DECERR.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.
- awaddr  in  ADDR_WIDTH  write address.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata  in  DATA_WIDTH  write data, already lane-aligned by the master.
- wstrb  in  4  byte-lane write enables.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bresp  out  2  write response: OKAY or DECERR.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.

Behaviour:
- Reset (async, active-high):
  - Both FSMs go to IDLE; rvalid = bvalid = 0; rdata = 0; rresp = bresp = 0.
  - arready = awready = wready = 1 once reset deasserts.
  - Memory array is not cleared.
- Address decode:
  - idx = (addr - BASE_ADDR) >> 2; addr[1:0] ignored.
  - In range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS. Otherwise DECERR.
- Read FSM: R_IDLE -> R_WAIT -> R_RESP.
  - arready = (state == R_IDLE), combinational from state only, never from arvalid.
  - AR handshake at cycle T: latch idx and range flag; counter loads RD_LATENCY-1.
    - If RD_LATENCY == 1, go straight to R_RESP.
    - Otherwise stay in R_WAIT, decrementing, until the counter reaches 0.
  - The edge entering R_RESP registers rdata = mem[idx] (0 if out of range) and rresp. rvalid rises at cycle T+RD_LATENCY.
  - In R_RESP, rvalid, rdata and rresp are held stable until rready = 1; the handshake returns the FSM to R_IDLE.
  - A new AR is accepted no earlier than the cycle after the R handshake (arready = 1 in R_IDLE).
  - rdata holds its last value outside rvalid.
- Write FSM: W_IDLE -> W_WAIT -> W_RESP.
  - W_IDLE:
    - awready = !aw_got and wready = !w_got.
    - AW and W may arrive in either order or in the same cycle. Each is latched and its flag set on handshake.
    - When both flags are set (cycle T = later handshake), enter W_WAIT with counter = WR_LATENCY-1, or W_RESP directly if WR_LATENCY == 1.
  - The edge entering W_RESP commits the write for every byte b with wstrb[b] = 1: mem[idx][8b+7:8b] = wdata[8b+7:8b].
    - Out of range: no write, bresp = DECERR.
    - wstrb = 0: no change, OKAY.
  - bvalid rises at cycle T+WR_LATENCY and is held until bready; the handshake clears both flags and returns to W_IDLE.
  - awready and wready are 0 in W_WAIT and W_RESP.
- Read/write ordering:
  - A read and a write to the same word are independent.
  - If the read-data register edge and the write-commit edge coincide, the read returns the pre-write data.
  - Otherwise each sees memory as of its own edge.
- Simultaneous events: an R handshake and a B handshake in the same cycle are both honoured.
- Reset mid-transaction: outstanding transactions are dropped without a response; a write not yet committed is lost, and a committed write remains.
- No combinational path from any input to any output. All *ready and *valid outputs are decoded from registered state.

Test Plan:
- Word write then read: AW+W in the same cycle to 0x8000_0010, wdata 0xDEAD_BEEF, wstrb 4'hF -> bvalid at T+1 with OKAY; AR to 0x8000_0010 -> rvalid at T+1 with rdata 0xDEAD_BEEF, OKAY.
- Byte lane: preload 0x1122_3344 at 0x8000_0020; write wdata 0x00AB_0000, wstrb 4'b0100 -> readback 0x11AB_3344.
- Independent channel order: W at cycle 0 with AW at cycle 3 -> wready = 0 from cycle 1 until the B handshake, bvalid at cycle 3+WR_LATENCY.
- Backpressure with RD_LATENCY=3, WR_LATENCY=2: hold rready and bready at 0 for 5 cycles -> rvalid/rdata and bvalid held stable, arready and awready remain 0, each completes on the ready edge.
- Decode error: AR to 0x7FFF_FFFC and write to BASE_ADDR + 0x4000 -> rresp = bresp = 2'b11, rdata = 0, no memory word changed.
- Reset mid-read: assert rst during R_WAIT -> rvalid = 0 immediately, arready = 1 after release, previously written data intact.
